sin_nco_ds_dac: RTL and testbench
=================================

// Module: sin_nco_ds_dac
// PURPOSE
//  Sine DDS plus 1-bit DAC. A divided phase counter steps through a D_CT-entry sine table.
//  The table sample feeds a first-order delta-sigma modulator that produces a 1-bit
//  pulse-density stream for an RC-filtered GPIO pin.
//  The block sits between the on-chip 48 MHz HF oscillator (instantiated by the top level,
//  not here) and the DAC and scope-sync pins.
//  Output frequency = f_clk / (max(nco_div,1) * D_CT); nco_div=188 at 48 MHz gives ~997 Hz.
// PARAMETERS
//  D_W     16   sample width (unsigned, offset-binary)
//  D_CT    256  table entries per sine period (power of two)
//  D_BITS  8    table index width, log2(D_CT)
//  DIV_W   16   width of nco_div
// PORTS
//  clk         in   1       system clock (48 MHz HFOSC)
//  rst_n       in   1       asynchronous reset, active low
//  nco_div     in   DIV_W   clocks per table step; 0 is treated as 1
//  nco_out     out  D_W     current sine sample, registered
//  ncoovfsync  out  1       one-clock pulse when the index wraps D_CT-1 -> 0
//  mod_dout    out  1       delta-sigma bitstream, registered
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - div_cnt=0, idx=0, acc=0.
//   - nco_out=2^(D_W-1) (16'h8000), ncoovfsync=0, mod_dout=0.
//  Divider:
//   - div_max = (nco_div==0) ? 0 : nco_div-1, compared on every cycle.
//   - If div_cnt >= div_max: div_cnt<=0 and step asserted; otherwise div_cnt<=div_cnt+1.
//   - nco_div changes take effect immediately. Lowering nco_div below the current count
//     forces a step on the next cycle, with no long wrap.
//  Phase index:
//   - On step: idx<=idx+1, modulo D_CT, natural D_BITS-bit wrap.
//   - ncoovfsync<=1 for exactly the one cycle in which idx goes D_CT-1 -> 0; else 0.
//  Sine table:
//   - lut[i] = round(32768 + 32767*sin(2*pi*i/D_CT)), range 1..65535.
//   - D_CT=256 anchors: lut[0]=32768, lut[64]=65535, lut[128]=32768, lut[192]=1.
//   - Table is constant; no runtime writes.
//  nco_out: registered from lut[idx], so it follows idx with 1 clock of latency.
//  Modulator (first order, error feedback via carry):
//   - sum = {1'b0,acc} + {1'b0,nco_out}, D_W+1 bits.
//   - acc<=sum[D_W-1:0]; mod_dout<=sum[D_W].
//   - Ones density = nco_out/2^D_W.
//   - nco_out=0 gives all zeros; 65535 gives 65535 ones in every 65536 clocks.
//  Boundary conditions:
//   - nco_div=1 and nco_div=0 both step every clock; ncoovfsync then pulses every D_CT clocks.
//   - Reset mid-period returns to idx 0 and midscale; the first step occurs div_max+1 clocks
//     after release.
//   - No overflow beyond the carry: acc is always < 2^D_W.
// STRUCTURE
//  Shared package sin_nco_pkg:
//   - D_W, D_CT and D_BITS defaults.
//   - The precomputed sine table as a localparam array, generated offline so synthesis
//     needs no $sin.
//  Sub-module sin_lut_rom (idx -> registered sample).
//  Divider, index and modulator stay inline in the top-level block.
// TESTING
//  1. Reset: hold rst_n=0 with nco_div=8 -> nco_out=16'h8000, mod_dout=0, ncoovfsync=0;
//     the first idx step lands 8 clocks after release.
//  2. nco_div=8: nco_out changes every 8 clocks, ncoovfsync pulses every 2048 clocks,
//     nco_out=65535 exactly 64 steps after the wrap pulse.
//  3. Table check with nco_div=1: over one 256-clock period sample idx 0/64/128/192 ->
//     32768 / 65535 / 32768 / 1; full table matches the reference model bit-exact.
//  4. Modulator density, nco_div=8: count mod_dout ones over 4 whole periods (8192 clocks)
//     -> 4096 +/-1. With the table forced constant 16'h4000 via the ROM override,
//     1 of every 4 output bits is 1.
//  5. Divider edges: nco_div=0 behaves identically to nco_div=1. Changing nco_div 100 -> 3
//     while div_cnt=50 -> step on the next clock, then every 3 clocks.
//  6. Reset mid-operation: assert rst_n=0 at idx=100 -> outputs return to reset values
//     asynchronously; after release the sequence restarts from idx 0.

Source files
------------

// File: rtl/sin_nco_pkg.sv
// Shared constants for the sine NCO / delta-sigma DAC.
// Quarter-wave sine table, round(32768 + 32767*sin(2*pi*k/256)) for k = 0..64.
package sin_nco_pkg;

   localparam int D_W    = 16;
   localparam int D_CT   = 256;
   localparam int D_BITS = 8;
   localparam int DIV_W  = 16;
   localparam int Q_CT   = D_CT / 4;

   localparam logic [D_W-1:0] MID = 16'h8000;

   localparam logic [D_W-1:0] SIN_QTR [Q_CT+1] = '{
      16'd32768, 16'd33572, 16'd34376, 16'd35178,
      16'd35980, 16'd36779, 16'd37576, 16'd38370,
      16'd39161, 16'd39947, 16'd40730, 16'd41507,
      16'd42280, 16'd43046, 16'd43807, 16'd44561,
      16'd45307, 16'd46047, 16'd46778, 16'd47500,
      16'd48214, 16'd48919, 16'd49614, 16'd50298,
      16'd50972, 16'd51636, 16'd52287, 16'd52927,
      16'd53555, 16'd54171, 16'd54773, 16'd55362,
      16'd55938, 16'd56499, 16'd57047, 16'd57579,
      16'd58097, 16'd58600, 16'd59087, 16'd59558,
      16'd60013, 16'd60451, 16'd60873, 16'd61278,
      16'd61666, 16'd62036, 16'd62389, 16'd62724,
      16'd63041, 16'd63339, 16'd63620, 16'd63881,
      16'd64124, 16'd64348, 16'd64553, 16'd64739,
      16'd64905, 16'd65053, 16'd65180, 16'd65289,
      16'd65377, 16'd65446, 16'd65496, 16'd65525,
      16'd65535
   };

   function automatic logic [DIV_W-1:0] div_limit(
      input logic [DIV_W-1:0] div
   );
      return (div == '0) ? '0 : div - DIV_W'(1);
   endfunction

endpackage

// File: rtl/sin_lut_rom.sv
// Sine table lookup, idx -> registered offset-binary sample.
// Quarter-wave storage: second half is the two's complement of the first.
module sin_lut_rom
   import sin_nco_pkg::*;
#(
   parameter bit             FORCE_EN  = 1'b0,
   parameter logic [D_W-1:0] FORCE_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [D_BITS-1:0] idx,
   output logic [D_W-1:0]    sample
);

   localparam logic [D_BITS-2:0] ONE_P = 1;
   localparam logic [D_W-1:0]    ONE_S = 1;

   logic [D_BITS-2:0] ph;
   logic [D_BITS-2:0] k;
   logic [D_W-1:0]    q;
   logic [D_W-1:0]    val;

   always_comb begin
      ph  = idx[D_BITS-2:0];
      k   = ph[D_BITS-2] ? (~ph + ONE_P) : ph;
      q   = SIN_QTR[k];
      // 65536 - q; q is never zero so no wrap issue
      val = idx[D_BITS-1] ? (~q + ONE_S) : q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sample <= MID;
      else        sample <= FORCE_EN ? FORCE_VAL : val;
   end

endmodule

// File: rtl/sin_nco_ds_dac.sv
// Sine DDS: divided phase counter, sine ROM, first-order delta-sigma 1-bit DAC.
// Output frequency = f_clk / (max(nco_div,1) * D_CT).
module sin_nco_ds_dac
   import sin_nco_pkg::*;
#(
   parameter bit             FORCE_EN  = 1'b0,
   parameter logic [D_W-1:0] FORCE_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] nco_div,
   output logic [D_W-1:0]   nco_out,
   output logic             ncoovfsync,
   output logic             mod_dout
);

   logic [DIV_W-1:0]  div_cnt;
   logic [DIV_W-1:0]  div_max;
   logic              step;
   logic [D_BITS-1:0] idx;
   logic [D_W-1:0]    acc;
   logic [D_W:0]      sum;

   assign div_max = div_limit(nco_div);
   // >= lets a lowered nco_div step at once instead of wrapping
   assign step    = (div_cnt >= div_max);
   assign sum     = {1'b0, acc} + {1'b0, nco_out};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt    <= '0;
         idx        <= '0;
         ncoovfsync <= 1'b0;
      end else begin
         div_cnt    <= step ? '0 : div_cnt + DIV_W'(1);
         ncoovfsync <= step && (idx == '1);
         if (step) idx <= idx + D_BITS'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         mod_dout <= 1'b0;
      end else begin
         acc      <= sum[D_W-1:0];
         mod_dout <= sum[D_W];
      end
   end

   sin_lut_rom #(
      .FORCE_EN  (FORCE_EN),
      .FORCE_VAL (FORCE_VAL)
   ) u_rom (
      .clk    (clk),
      .rst_n  (rst_n),
      .idx    (idx),
      .sample (nco_out)
   );

endmodule

// File: tb/tb_sin_nco_ds_dac.sv
// Directed bench for sin_nco_ds_dac.
// Reference samples come from $sin; anchors are hand constants.
module tb_sin_nco_ds_dac;

   logic        clk;
   logic        rst_n;
   logic [15:0] nco_div;
   logic [15:0] nco_out;
   logic        ncoovfsync;
   logic        mod_dout;
   logic [15:0] nco_out_k;
   logic        ovf_k;
   logic        dout_k;

   int n_chk;
   int n_err;

   sin_nco_ds_dac dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .nco_div    (nco_div),
      .nco_out    (nco_out),
      .ncoovfsync (ncoovfsync),
      .mod_dout   (mod_dout)
   );

   sin_nco_ds_dac #(
      .FORCE_EN  (1'b1),
      .FORCE_VAL (16'h4000)
   ) dut_k (
      .clk        (clk),
      .rst_n      (rst_n),
      .nco_div    (nco_div),
      .nco_out    (nco_out_k),
      .ncoovfsync (ovf_k),
      .mod_dout   (dout_k)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_lut(input int i);
      real r;
      r = 32768.0 + 32767.0 * $sin(2.0 * 3.14159265358979323846 * i / 256.0);
      return $rtoi(r + 0.5);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [15:0] div);
      rst_n   = 1'b0;
      nco_div = div;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_ovf(input int max, output int n);
      n = 0;
      for (int i = 1; i <= max; i++) begin
         tick(1);
         if (ncoovfsync) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      int first;
      int n;
      int ones;
      int ones_k;
      int dev;
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      nco_div = 16'd8;

      // 1: reset values and first step latency
      repeat (2) @(negedge clk);
      check("rst_nco_out", nco_out, 32'h8000);
      check("rst_mod_dout", mod_dout, 0);
      check("rst_ovf", ncoovfsync, 0);
      do_reset(16'd8);
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         if (nco_out != 16'h8000) begin
            first = i;
            break;
         end
      end
      check("first_step_edge", first, 9);
      check("first_step_val", nco_out, ref_lut(1));

      // 2: nco_div=8 period, wrap pulse, peak 64 steps after wrap
      wait_ovf(3000, n);
      check("ovf_first_div8", n, 2039);
      wait_ovf(3000, n);
      check("ovf_period_div8", n, 2048);
      tick(1);
      check("ovf_one_cycle", ncoovfsync, 0);
      tick(511);
      check("pre_peak", nco_out, 65525);
      tick(1);
      check("peak", nco_out, 65535);
      tick(7);
      check("peak_hold", nco_out, 65535);
      tick(1);
      check("after_peak", nco_out, 65525);

      // 3: full table with nco_div=1, then nco_div=0
      do_reset(16'd1);
      for (int k = 1; k <= 256; k++) begin
         tick(1);
         check("tab_div1", nco_out, ref_lut(k - 1));
         if (k == 1)   check("anchor0", nco_out, 32768);
         if (k == 65)  check("anchor64", nco_out, 65535);
         if (k == 129) check("anchor128", nco_out, 32768);
         if (k == 193) check("anchor192", nco_out, 1);
         if (k == 256) check("ovf_at_256", ncoovfsync, 1);
      end
      wait_ovf(400, n);
      check("ovf_period_div1", n, 256);
      do_reset(16'd0);
      for (int k = 1; k <= 256; k++) begin
         tick(1);
         check("tab_div0", nco_out, ref_lut(k - 1));
      end
      check("ovf_div0_256", ncoovfsync, 1);
      wait_ovf(400, n);
      check("ovf_period_div0", n, 256);

      // 4: modulator density
      do_reset(16'd8);
      ones = 0;
      ones_k = 0;
      for (int i = 0; i < 8192; i++) begin
         tick(1);
         ones += int'(mod_dout);
         if (i < 4096) ones_k += int'(dout_k);
      end
      dev = (ones > 4096) ? ones - 4096 : 4096 - ones;
      check("density_within_1", dev <= 1, 1);
      check("force_sample", nco_out_k, 16'h4000);
      check("density_quarter", ones_k, 1024);

      // 5: lowering nco_div mid-count steps at once
      do_reset(16'd100);
      tick(50);
      check("div100_hold", nco_out, 32768);
      nco_div = 16'd3;
      tick(1);
      check("div3_e51", nco_out, 32768);
      tick(1);
      check("div3_e52", nco_out, ref_lut(1));
      tick(2);
      check("div3_e54", nco_out, ref_lut(1));
      tick(1);
      check("div3_e55", nco_out, ref_lut(2));
      tick(2);
      check("div3_e57", nco_out, ref_lut(2));
      tick(1);
      check("div3_e58", nco_out, ref_lut(3));

      // 6: async reset mid-period
      do_reset(16'd1);
      tick(100);
      check("mid_idx100", nco_out, ref_lut(99));
      rst_n = 1'b0;
      #1;
      check("async_nco_out", nco_out, 32'h8000);
      check("async_mod_dout", mod_dout, 0);
      check("async_ovf", ncoovfsync, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      check("restart_e1", nco_out, ref_lut(0));
      tick(1);
      check("restart_e2", nco_out, ref_lut(1));
      tick(1);
      check("restart_e3", nco_out, ref_lut(2));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
